// File: rtl/risk_pkg.sv
// -----------------------------------------------------------------------------
// risk_pkg -- shared definitions for the risk alarm block.
//
// Holds the FSM state encoding, the bus/state widths, the default thresholds
// and persistence depth, and a small saturating-increment helper used for the
// ALERT entry counter.
// -----------------------------------------------------------------------------
package risk_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned RISK_W  = 8;
  localparam int unsigned COUNT_W = 8;

  // Default hysteresis thresholds and persistence depth.
  localparam logic [RISK_W-1:0] DEF_HI_TH   = 8'd170;
  localparam logic [RISK_W-1:0] DEF_LO_TH   = 8'd85;
  localparam int                DEF_PERSIST = 4;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_SAFE  = 2'd0,
    ST_WARN  = 2'd1,
    ST_ALERT = 2'd2
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage : risk_pkg

// File: rtl/risk_alarm_if.sv
// -----------------------------------------------------------------------------
// risk_alarm_if -- sample bus from the fuzzy stage into risk_alarm.
//
// Signals:
//   risk_valid : new risk sample present this cycle (one-cycle pulse)
//   risk[7:0]  : defuzzified risk value
//   ack        : operator acknowledge, level sampled every cycle
//
// Modports:
//   master : the producer (fuzzy stage / operator panel) drives everything
//   slave  : risk_alarm samples everything
// -----------------------------------------------------------------------------
interface risk_alarm_if;
  import risk_pkg::*;

  logic              risk_valid;
  logic [RISK_W-1:0] risk;
  logic              ack;

  modport master (output risk_valid, output risk, output ack);
  modport slave  (input  risk_valid, input  risk, input  ack);

endinterface : risk_alarm_if

// File: rtl/persist_cnt.sv
// -----------------------------------------------------------------------------
// persist_cnt -- persistence counter for the risk alarm FSM.
//
// Counts consecutive qualifying samples. o_term is high when the count already
// holds PERSIST-1 qualifying samples, i.e. the next qualifying sample is the
// PERSIST-th one. The owner is expected to clear on that sample, so in normal
// use the count never goes above PERSIST-1; the increment is additionally
// bounded at PERSIST so the invariant holds even if misused.
//
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, clears the count
//   i_inc   : count one qualifying sample
//   i_clr   : clear the count (wins over i_inc)
//   o_term  : next qualifying sample completes the persistence run
// -----------------------------------------------------------------------------
module persist_cnt #(
  parameter int PERSIST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_term
);

  // Guarded so a bad PERSIST reaches the top-level elaboration error instead
  // of a zero-width vector here.
  localparam int CW = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(PERSIST);
  localparam logic [CW-1:0] CNT_TERM = CW'(PERSIST - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // With PERSIST=1 the count is always 0 == CNT_TERM, giving single-sample
  // transitions.
  assign o_term = (r_cnt == CNT_TERM);

endmodule : persist_cnt

// File: rtl/risk_alarm.sv
// -----------------------------------------------------------------------------
// risk_alarm -- three-state hysteresis alarm on a stream of risk samples.
//
// SAFE -> WARN on one sample >= LO_TH. WARN -> ALERT after PERSIST consecutive
// samples >= HI_TH. ALERT -> SAFE after PERSIST consecutive samples < LO_TH.
// Cycles without risk_valid are ignored entirely. Every output is a register
// and reflects a sample one cycle after the edge that captured it.
//
// Optional feature (macro RISK_ALARM_PEAK_EN): adds output peak[7:0], the
// largest valid risk seen since reset or the last ack.
//
// Parameters:
//   HI_TH   : alarm-entry threshold (unsigned, reaching it counts)
//   LO_TH   : warn-entry / alarm-release threshold, must be below HI_TH
//   PERSIST : consecutive samples needed to enter and to leave ALERT (>= 1)
//
// Ports:
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   bus           : risk_alarm_if.slave (risk_valid, risk, ack)
//   warn          : state is WARN
//   alarm         : state is ALERT
//   alarm_latched : sticky flag set on each ALERT entry, cleared by ack
//                   outside ALERT
//   state[1:0]    : SAFE=0, WARN=1, ALERT=2
//   alert_count   : number of ALERT entries, saturating at 255
//   peak[7:0]     : (RISK_ALARM_PEAK_EN only) maximum valid risk
// -----------------------------------------------------------------------------
module risk_alarm
  import risk_pkg::*;
#(
  parameter logic [RISK_W-1:0] HI_TH   = DEF_HI_TH,
  parameter logic [RISK_W-1:0] LO_TH   = DEF_LO_TH,
  parameter int                PERSIST = DEF_PERSIST
) (
  input  logic               clk,
  input  logic               rst_n,
  risk_alarm_if.slave        bus,
  output logic               warn,
  output logic               alarm,
  output logic               alarm_latched,
  output logic [STATE_W-1:0] state,
  output logic [COUNT_W-1:0] alert_count
`ifdef RISK_ALARM_PEAK_EN
  ,
  output logic [RISK_W-1:0]  peak
`endif
);

  // ---------------------------------------------------------------------------
  // Parameter sanity: refuse to build a configuration that has no hysteresis
  // or no persistence.
  // ---------------------------------------------------------------------------
  if (PERSIST < 1) begin : g_bad_persist
    $error("risk_alarm: PERSIST must be at least 1");
  end
  if (LO_TH >= HI_TH) begin : g_bad_thresholds
    $error("risk_alarm: LO_TH must be strictly below HI_TH");
  end

  // ---------------------------------------------------------------------------
  // Registers and next-state wires
  // ---------------------------------------------------------------------------
  state_e             r_state;
  logic               r_warn;
  logic               r_alarm;
  logic               r_latched;
  logic [COUNT_W-1:0] r_alert_count;

  state_e             w_next_state;
  logic               w_cnt_inc;
  logic               w_cnt_clr;
  logic               w_cnt_term;
  logic               w_alert_entry;
  logic               w_at_lo;
  logic               w_at_hi;

  // Unsigned compares; equality counts as reaching the threshold.
  assign w_at_lo = (bus.risk >= LO_TH);
  assign w_at_hi = (bus.risk >= HI_TH);

  // ---------------------------------------------------------------------------
  // Persistence counter
  // ---------------------------------------------------------------------------
  persist_cnt #(
    .PERSIST (PERSIST)
  ) u_persist_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_cnt_inc),
    .i_clr  (w_cnt_clr),
    .o_term (w_cnt_term)
  );

  // ---------------------------------------------------------------------------
  // FSM: next state and counter control
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_cnt_inc    = 1'b0;
    w_cnt_clr    = 1'b0;

    if (bus.risk_valid) begin
      unique case (r_state)
        ST_SAFE: begin
          if (w_at_lo) begin
            w_next_state = ST_WARN;
            w_cnt_clr    = 1'b1;
          end
        end

        ST_WARN: begin
          if (w_at_hi) begin
            // The PERSIST-th consecutive high sample completes the run.
            if (w_cnt_term) begin
              w_next_state = ST_ALERT;
              w_cnt_clr    = 1'b1;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end else if (w_at_lo) begin
            // Mid-band sample breaks the run but keeps WARN.
            w_cnt_clr = 1'b1;
          end else begin
            w_next_state = ST_SAFE;
            w_cnt_clr    = 1'b1;
          end
        end

        ST_ALERT: begin
          if (!w_at_lo) begin
            if (w_cnt_term) begin
              w_next_state = ST_SAFE;
              w_cnt_clr    = 1'b1;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end else begin
            // Anything at or above LO_TH restarts the release run.
            w_cnt_clr = 1'b1;
          end
        end

        default: begin
          w_next_state = ST_SAFE;
          w_cnt_clr    = 1'b1;
        end
      endcase
    end

    w_alert_entry = (w_next_state == ST_ALERT) && (r_state != ST_ALERT);
  end

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SAFE;
      r_warn  <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_warn  <= (w_next_state == ST_WARN);
      r_alarm <= (w_next_state == ST_ALERT);
    end
  end

  // Sticky alarm flag and entry counter. Ack is judged against the current
  // state, so an ack arriving with the sample that leaves ALERT is still
  // ignored; an entry in the same cycle as ack sets the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latched     <= 1'b0;
      r_alert_count <= '0;
    end else begin
      if (w_alert_entry) begin
        r_latched     <= 1'b1;
        r_alert_count <= sat_inc(r_alert_count);
      end else if (bus.ack && (r_state != ST_ALERT)) begin
        r_latched <= 1'b0;
      end
    end
  end

  assign warn          = r_warn;
  assign alarm         = r_alarm;
  assign alarm_latched = r_latched;
  assign state         = r_state;
  assign alert_count   = r_alert_count;

`ifdef RISK_ALARM_PEAK_EN
  // ---------------------------------------------------------------------------
  // Peak tracker: ack restarts tracking, seeded with the coincident sample.
  // ---------------------------------------------------------------------------
  logic [RISK_W-1:0] r_peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (bus.ack) begin
      r_peak <= bus.risk_valid ? bus.risk : '0;
    end else if (bus.risk_valid && (bus.risk > r_peak)) begin
      r_peak <= bus.risk;
    end
  end

  assign peak = r_peak;
`endif

endmodule : risk_alarm

// File: tb/tb_risk_alarm.sv
// -----------------------------------------------------------------------------
// tb_risk_alarm -- directed self-checking bench for risk_alarm (default
// thresholds 170/85, PERSIST=4). Inputs change on the falling edge and outputs
// are read on the falling edge, half a period after the capturing rising edge.
// Observed outputs are compared as one packed word:
//   {state[1:0], warn, alarm, alarm_latched, alert_count[7:0]}
// -----------------------------------------------------------------------------
module tb_risk_alarm;

  localparam logic [1:0] S_SAFE  = 2'd0;
  localparam logic [1:0] S_WARN  = 2'd1;
  localparam logic [1:0] S_ALERT = 2'd2;

  logic       clk;
  logic       rst_n;
  logic       warn;
  logic       alarm;
  logic       alarm_latched;
  logic [1:0] state;
  logic [7:0] alert_count;
`ifdef RISK_ALARM_PEAK_EN
  logic [7:0] peak;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  risk_alarm_if u_if ();

  risk_alarm #(
    .HI_TH   (8'd170),
    .LO_TH   (8'd85),
    .PERSIST (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (u_if),
    .warn          (warn),
    .alarm         (alarm),
    .alarm_latched (alarm_latched),
    .state         (state),
    .alert_count   (alert_count)
`ifdef RISK_ALARM_PEAK_EN
    ,
    .peak          (peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [12:0] w_obs = {state, warn, alarm, alarm_latched, alert_count};

  function automatic logic [12:0] ev(input logic [1:0] s, input logic w,
                                     input logic a, input logic l,
                                     input logic [7:0] c);
    return {s, w, a, l, c};
  endfunction

  // One valid sample: presented at a falling edge, captured at the next
  // rising edge, outputs readable at the following falling edge.
  task automatic sample(input logic [7:0] v);
    u_if.risk_valid = 1'b1;
    u_if.risk       = v;
    @(negedge clk);
    u_if.risk_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    u_if.risk_valid = 1'b0;
    u_if.risk       = 8'd0;
    u_if.ack        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] exp_v;
    rst_n           = 1'b1;
    u_if.risk_valid = 1'b0;
    u_if.risk       = 8'd0;
    u_if.ack        = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_v = ev(S_SAFE, 0, 0, 0, 8'd0);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", w_obs, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alarm_entry();
    logic [12:0] exp_v;
    do_reset();
    sample(8'd100);
    exp_v = ev(S_WARN, 1, 0, 0, 8'd0);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL entry_warn: got %h want %h", w_obs, exp_v);
    end
    repeat (3) sample(8'd200);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL entry_third_high: got %h want %h", w_obs, exp_v);
    end
    sample(8'd200);
    exp_v = ev(S_ALERT, 0, 1, 1, 8'd1);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL entry_alert: got %h want %h", w_obs, exp_v);
    end
  endtask

  // Mid-band sample restarts the entry run; ends in ALERT for the next test.
  task automatic test_warn_persist();
    logic [7:0]  seq [7] = '{8'd200, 8'd200, 8'd200, 8'd150, 8'd200, 8'd200, 8'd200};
    logic        alarm_seen;
    logic [12:0] exp_v;
    do_reset();
    sample(8'd100);
    alarm_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample(seq[i]);
      alarm_seen = alarm_seen | alarm;
    end
    exp_v = ev(S_WARN, 1, 0, 0, 8'd0);
    n_tests++;
    if ({w_obs, alarm_seen} !== {exp_v, 1'b0}) begin
      n_fail++;
      $display("FAIL warn_persist: got %h seen=%b want %h seen=0", w_obs, alarm_seen, exp_v);
    end
    sample(8'd200);
    exp_v = ev(S_ALERT, 0, 1, 1, 8'd1);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL warn_persist_enter: got %h want %h", w_obs, exp_v);
    end
  endtask

  task automatic test_alert_exit();
    logic [7:0]  seq [7] = '{8'd50, 8'd50, 8'd50, 8'd90, 8'd50, 8'd50, 8'd50};
    logic [12:0] exp_v;
    u_if.ack = 1'b1;
    exp_v = ev(S_ALERT, 0, 1, 1, 8'd1);
    for (int i = 0; i < 7; i++) begin
      sample(seq[i]);
      n_tests++;
      if (w_obs !== exp_v) begin
        n_fail++;
        $display("FAIL alert_hold[%0d]: got %h want %h", i, w_obs, exp_v);
      end
    end
    sample(8'd50);
    exp_v = ev(S_SAFE, 0, 0, 1, 8'd1);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL alert_exit: got %h want %h", w_obs, exp_v);
    end
    @(negedge clk);
    exp_v = ev(S_SAFE, 0, 0, 0, 8'd1);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL ack_in_safe: got %h want %h", w_obs, exp_v);
    end
    u_if.ack = 1'b0;
  endtask

  task automatic test_edges();
    logic [7:0]  seq [7] = '{8'd84, 8'd84, 8'd84, 8'd85, 8'd84, 8'd84, 8'd84};
    logic [12:0] exp_v;
    do_reset();
    sample(8'd85);
    exp_v = ev(S_WARN, 1, 0, 0, 8'd0);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL edge_lo_enter: got %h want %h", w_obs, exp_v);
    end
    sample(8'd84);
    exp_v = ev(S_SAFE, 0, 0, 0, 8'd0);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL edge_lo_leave: got %h want %h", w_obs, exp_v);
    end
    sample(8'd85);
    repeat (4) sample(8'd170);
    exp_v = ev(S_ALERT, 0, 1, 1, 8'd1);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL edge_hi_enter: got %h want %h", w_obs, exp_v);
    end
    for (int i = 0; i < 7; i++) sample(seq[i]);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL edge_release_restart: got %h want %h", w_obs, exp_v);
    end
    sample(8'd84);
    exp_v = ev(S_SAFE, 0, 0, 1, 8'd1);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL edge_release: got %h want %h", w_obs, exp_v);
    end
    sample(8'd100);
    u_if.risk = 8'd255;
    repeat (10) @(negedge clk);
    exp_v = ev(S_WARN, 1, 0, 1, 8'd1);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL idle_hold: got %h want %h", w_obs, exp_v);
    end
    // Idle cycles must not have advanced the entry run.
    repeat (3) sample(8'd200);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL idle_no_count: got %h want %h", w_obs, exp_v);
    end
    sample(8'd200);
    exp_v = ev(S_ALERT, 0, 1, 1, 8'd2);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL idle_then_enter: got %h want %h", w_obs, exp_v);
    end
  endtask

  // Starts in ALERT from test_edges.
  task automatic test_async_reset();
    logic [12:0] exp_v;
    repeat (2) sample(8'd50);
    #2 rst_n = 1'b0;
    #1;
    exp_v = ev(S_SAFE, 0, 0, 0, 8'd0);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", w_obs, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sample(8'd100);
    exp_v = ev(S_WARN, 1, 0, 0, 8'd0);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL resume_after_reset: got %h want %h", w_obs, exp_v);
    end
  endtask

  task automatic test_saturation();
    logic [12:0] exp_v;
    do_reset();
    for (int e = 1; e <= 256; e++) begin
      sample(8'd100);
      repeat (4) sample(8'd200);
      if (e == 1 || e == 255 || e == 256) begin
        exp_v = ev(S_ALERT, 0, 1, 1, (e == 1) ? 8'd1 : 8'd255);
        n_tests++;
        if (w_obs !== exp_v) begin
          n_fail++;
          $display("FAIL saturation_entry_%0d: got %h want %h", e, w_obs, exp_v);
        end
      end
      repeat (4) sample(8'd50);
    end
  endtask

  // Starts in SAFE with alarm_latched=1 and alert_count=255.
  task automatic test_ack_set_wins();
    logic [12:0] exp_v;
    u_if.ack = 1'b1;
    @(negedge clk);
    u_if.ack = 1'b0;
    exp_v = ev(S_SAFE, 0, 0, 0, 8'd255);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL ack_clear: got %h want %h", w_obs, exp_v);
    end
    sample(8'd100);
    repeat (3) sample(8'd200);
    u_if.ack = 1'b1;
    sample(8'd200);
    exp_v = ev(S_ALERT, 0, 1, 1, 8'd255);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL ack_set_wins: got %h want %h", w_obs, exp_v);
    end
    @(negedge clk);
    n_tests++;
    if (w_obs !== exp_v) begin
      n_fail++;
      $display("FAIL ack_ignored_alert: got %h want %h", w_obs, exp_v);
    end
    u_if.ack = 1'b0;
  endtask

`ifdef RISK_ALARM_PEAK_EN
  task automatic test_peak();
    do_reset();
    n_tests++;
    if (peak !== 8'd0) begin
      n_fail++;
      $display("FAIL peak_reset: got %0d want 0", peak);
    end
    sample(8'd40);
    sample(8'd220);
    sample(8'd90);
    n_tests++;
    if (peak !== 8'd220) begin
      n_fail++;
      $display("FAIL peak_max: got %0d want 220", peak);
    end
    u_if.ack = 1'b1;
    sample(8'd60);
    u_if.ack = 1'b0;
    n_tests++;
    if (peak !== 8'd60) begin
      n_fail++;
      $display("FAIL peak_ack_load: got %0d want 60", peak);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alarm_entry();
    test_warn_persist();
    test_alert_exit();
    test_edges();
    test_async_reset();
    test_saturation();
    test_ack_set_wins();
`ifdef RISK_ALARM_PEAK_EN
    test_peak();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_risk_alarm

// File: doc/risk_alarm.md
RISK_ALARM -- requirements
Module: risk_alarm

Interface
REQ-001 SHALL have parameter HI_TH, default 170, alarm-entry risk threshold (8-bit).
REQ-002 SHALL have parameter LO_TH, default 85, warn-entry and alarm-release threshold (8-bit).
REQ-003 SHALL have parameter PERSIST, default 4, consecutive qualifying samples needed for ALERT entry and ALERT exit.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port risk_valid  input  1  new risk sample present this cycle (upstream enable, one-cycle pulse).
REQ-007 SHALL have port risk  input  8  defuzzified risk value from the fuzzy stage.
REQ-008 SHALL have port ack  input  1  operator acknowledge, level sampled each cycle.
REQ-009 SHALL have port warn  output  1  state is WARN.
REQ-010 SHALL have port alarm  output  1  state is ALERT.
REQ-011 SHALL have port alarm_latched  output  1  sticky alarm flag, held until acknowledged.
REQ-012 SHALL have port state  output  2  encoded FSM state (SAFE=0, WARN=1, ALERT=2).
REQ-013 SHALL have port alert_count  output  8  number of ALERT entries, saturating at 255.

Function
REQ-014 SHALL ignore risk in any cycle where risk_valid=0; state, counter and flags hold.
REQ-015 SHALL register all outputs; they reflect a sample one cycle after the edge on which risk_valid=1 is sampled.
REQ-016 SAFE: a valid sample >= LO_TH SHALL move to WARN and clear the persistence counter; otherwise stay in SAFE.
REQ-017 WARN: a valid sample >= HI_TH SHALL increment the counter; the PERSIST-th consecutive such sample SHALL move to ALERT and clear the counter.
REQ-018 WARN: a valid sample in [LO_TH, HI_TH) SHALL clear the counter; a valid sample < LO_TH SHALL return to SAFE with the counter cleared.
REQ-019 ALERT: a valid sample < LO_TH SHALL increment the counter; the PERSIST-th consecutive such sample SHALL return to SAFE; any valid sample >= LO_TH SHALL clear the counter.
REQ-020 The persistence counter SHALL be $clog2(PERSIST+1) bits wide and never exceed PERSIST.
REQ-021 Each entry to ALERT SHALL set alarm_latched and increment alert_count; at 255 alert_count SHALL hold.
REQ-022 ack=1 SHALL clear alarm_latched only when state is not ALERT; ack in ALERT SHALL be ignored.
REQ-023 If ALERT entry and ack coincide, set SHALL win (alarm_latched=1).
REQ-024 PERSIST=1 SHALL give single-sample transitions; elaboration SHALL fail if PERSIST<1 or LO_TH>=HI_TH.
REQ-025 Comparisons SHALL be unsigned 8-bit; equality to a threshold counts as reaching it.

Reset
REQ-026 rst_n=0 SHALL immediately force state=SAFE, counter=0, warn=0, alarm=0, alarm_latched=0, alert_count=0 (and peak=0 if built), including mid-count.
REQ-027 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 With RISK_ALARM_PEAK_EN defined, SHALL add output peak[7:0], the maximum valid risk since reset or last ack; ack loads 0, or risk if risk_valid coincides.
REQ-029 Without RISK_ALARM_PEAK_EN, the peak port and register SHALL be absent; all other behaviour is unchanged.

Structure
REQ-030 The state enum, state widths and default thresholds (170, 85, 4) SHALL live in shared package risk_pkg.
REQ-031 The persistence counter (increment, clear, terminal flag) SHALL be sub-module persist_cnt; the FSM and flags stay in risk_alarm.

Verification
REQ-032 Reset, then valid risk=100 -> WARN; then 4 valid risk=200 -> alarm=1, alarm_latched=1, alert_count=1 one cycle after the 4th sample.
REQ-033 In WARN: 3x risk=200, 1x risk=150, 3x risk=200 -> remains WARN; alarm never asserts.
REQ-034 In ALERT: 3x risk=50, 1x risk=90, 4x risk=50 -> SAFE only after the last sample; ack held during ALERT -> alarm_latched stays 1; ack after SAFE -> 0.
REQ-035 Edges: risk=85 from SAFE -> WARN; risk=84 from WARN -> SAFE; risk_valid=0 with risk=255 for 10 cycles -> no change.
REQ-036 rst_n pulsed low mid-count in ALERT (asynchronous, between edges) -> all outputs 0 immediately; 256 ALERT entries -> alert_count=255.
REQ-037 With RISK_ALARM_PEAK_EN: samples 40, 220, 90 -> peak=220; ack together with valid risk=60 -> peak=60.
